ldpc_info_packer: RTL and testbench
===================================

// Module: ldpc_info_packer
// PURPOSE
//  Front end of the LDPC encoder datapath. Collects info bits arriving in IN_W-bit chunks into WIDTH-bit
//  (360-bit) parallel groups. Presents each group, tagged with its index in the frame, to the
//  fixed-rotation barrel_shift_val stage and the parity accumulator. Valid/ready on both sides; holds
//  one complete group while the next one assembles.
// PARAMETERS
//  WIDTH     360  bits per parallel group (output word width)
//  IN_W      8    input chunk width; WIDTH % IN_W == 0 is required (elaboration error otherwise)
//  K_GROUPS  90   info groups per frame (Kldpc/360); group index wraps after K_GROUPS-1
// PORTS
//  clk        in   1                   system clock, all logic on posedge
//  rst        in   1                   reset, asynchronous, active-high
//  in_data    in   IN_W                info chunk; MSB is the earliest bit in time
//  in_valid   in   1                   in_data valid
//  in_sof     in   1                   qualifies in_valid: chunk is first of a new frame
//  in_ready   out  1                   packer accepts chunk this cycle
//  out_data   out  WIDTH               assembled group; earliest bit at out_data[WIDTH-1]
//  out_grp    out  $clog2(K_GROUPS)    group index within frame, 0..K_GROUPS-1
//  out_last   out  1                   out_grp == K_GROUPS-1
//  out_valid  out  1                   output group valid
//  out_ready  in   1                   consumer takes group
//  err_sync   out  1                   1-cycle pulse: in_sof arrived with a partial group pending
// BEHAVIOUR
//  - CHUNKS = WIDTH/IN_W. Accept = in_valid & in_ready. Take = out_valid & out_ready.
//  - Reset: chunk_cnt=0, grp_cnt=0, asm_reg=0, out_data=0, out_grp=0, out_last=0, out_valid=0, err_sync=0.
//    in_ready is 1 one cycle after reset deasserts. Reset mid-group discards all partial and held data.
//  - Assembly: on accept, asm_reg <= {asm_reg[WIDTH-IN_W-1:0], in_data}; chunk_cnt increments.
//  - in_ready = (chunk_cnt != CHUNKS-1) | ~out_valid | out_ready. Only the closing chunk stalls.
//  - Accepting the closing chunk (chunk_cnt==CHUNKS-1):
//    - {asm_reg, in_data} is loaded into out_data, out_grp <= grp_cnt, out_valid <= 1.
//    - chunk_cnt <= 0. grp_cnt <= (grp_cnt==K_GROUPS-1) ? 0 : grp_cnt+1.
//    - Latency: closing chunk accepted at cycle t -> out_valid=1 at t+1.
//  - Take without a simultaneous load: out_valid <= 0. Take and load in the same cycle: out_valid stays 1
//    with the new group (full throughput, no bubble). out_data is stable while out_valid & ~out_ready.
//  - in_sof on an accepted chunk:
//    - The chunk becomes chunk 0 of group 0 (grp_cnt=0).
//    - If chunk_cnt != 0 beforehand, the partial group is dropped and err_sync pulses the next cycle.
//    - A group already held in the output register is unaffected.
//    - in_sof with chunk_cnt==0 and grp_cnt!=0 (short frame) restarts grp_cnt silently, no error.
//  - CHUNKS==1: every accepted chunk is a closing chunk.
//  - in_sof is ignored when in_valid=0 or when in_ready=0.
//  - No combinational path from in_* to out_*. in_ready depends combinationally on out_ready only.
// STRUCTURE
//  - Shared package ldpc_pkg: GROUP_W=360, K_GROUPS table per code rate, GRP_IDX_W.
//  - One flat module: chunk counter, group counter, assembly shift register, output holding register.
//  - No sub-module. The output register is the only buffer.
// TESTING
//  1. Reset, then stream 45 bytes 0x00..0x2C, out_ready=1:
//     out_valid at cycle after byte 44, out_data[359:352]=0x00, [7:0]=0x2C, out_grp=0.
//  2. out_ready=0 and stream 90 bytes:
//     first group held, in_ready drops on byte 89 (chunk 44 of group 1).
//     out_ready=1 -> group 0 then group 1 on consecutive cycles, no bubble.
//  3. Full frame, K_GROUPS=90, continuous input:
//     out_grp runs 0..89, out_last only on group 89, next frame's first group shows out_grp=0.
//  4. Send 10 bytes, then a byte with in_sof=1:
//     err_sync pulses once, the next 44 bytes complete group 0 starting at the sof byte.
//  5. Assert rst asynchronously mid-group while out_valid=1:
//     out_valid=0 immediately, the next 45 bytes produce out_grp=0.
//  6. Random in_valid/out_ready over 1000 groups against a scoreboard model:
//     no loss, duplication or reordering, out_data stable during stalls.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared LDPC encoder constants: parallel group width, info-group counts per code rate.
package ldpc_pkg;

  localparam int GROUP_W      = 360;
  localparam int K_GROUPS_DEF = 90;
  localparam int K_GROUPS_MAX = 162;
  localparam int GRP_IDX_W    = $clog2(K_GROUPS_MAX);

  typedef enum logic [3:0] {
    RATE_1_4  = 4'd0,
    RATE_1_3  = 4'd1,
    RATE_2_5  = 4'd2,
    RATE_1_2  = 4'd3,
    RATE_3_5  = 4'd4,
    RATE_2_3  = 4'd5,
    RATE_3_4  = 4'd6,
    RATE_4_5  = 4'd7,
    RATE_5_6  = 4'd8,
    RATE_8_9  = 4'd9,
    RATE_9_10 = 4'd10
  } code_rate_e;

  // Kldpc/360 for the 64800-bit frame, indexed by code rate
  function automatic logic [GRP_IDX_W-1:0] k_groups_for(input code_rate_e rate);
    logic [GRP_IDX_W-1:0] k;
    case (rate)
      RATE_1_4:  k = GRP_IDX_W'(45);
      RATE_1_3:  k = GRP_IDX_W'(60);
      RATE_2_5:  k = GRP_IDX_W'(72);
      RATE_1_2:  k = GRP_IDX_W'(90);
      RATE_3_5:  k = GRP_IDX_W'(108);
      RATE_2_3:  k = GRP_IDX_W'(120);
      RATE_3_4:  k = GRP_IDX_W'(135);
      RATE_4_5:  k = GRP_IDX_W'(144);
      RATE_5_6:  k = GRP_IDX_W'(150);
      RATE_8_9:  k = GRP_IDX_W'(160);
      RATE_9_10: k = GRP_IDX_W'(162);
      default:   k = GRP_IDX_W'(K_GROUPS_DEF);
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ldpc_info_packer.sv
// Packs IN_W-bit info chunks (MSB first) into WIDTH-bit groups tagged with their
// index in the frame; one output holding register decouples the consumer.
module ldpc_info_packer
  import ldpc_pkg::*;
#(
  parameter int WIDTH    = GROUP_W,
  parameter int IN_W     = 8,
  parameter int K_GROUPS = K_GROUPS_DEF
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [IN_W-1:0]                                  in_data,
  input  logic                                             in_valid,
  input  logic                                             in_sof,
  output logic                                             in_ready,
  output logic [WIDTH-1:0]                                 out_data,
  output logic [((K_GROUPS > 1) ? $clog2(K_GROUPS) : 1)-1:0] out_grp,
  output logic                                             out_last,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic                                             err_sync
);

  localparam int CHUNKS = WIDTH / IN_W;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int GRP_W  = (K_GROUPS > 1) ? $clog2(K_GROUPS) : 1;
  localparam int ASM_W  = (CHUNKS > 1) ? (WIDTH - IN_W) : IN_W;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic [GRP_W-1:0] LAST_GRP   = GRP_W'(K_GROUPS - 1);

  if ((IN_W < 1) || (WIDTH < IN_W) || ((WIDTH % IN_W) != 0)) begin : g_bad_width
    $error("ldpc_info_packer: WIDTH must be a non-zero multiple of IN_W");
  end

  logic                 rdy_en_r;
  logic [CNT_W-1:0]     chunk_cnt_r;
  logic [GRP_W-1:0]     grp_cnt_r;
  logic [ASM_W-1:0]     asm_r;

  logic                 accept_s;
  logic                 load_s;
  logic                 err_nxt_s;
  logic [CNT_W-1:0]     chunk_nxt_s;
  logic [GRP_W-1:0]     grp_nxt_s;
  logic [GRP_W-1:0]     load_grp_s;
  logic [ASM_W-1:0]     asm_nxt_s;
  logic [ASM_W-1:0]     asm_shift_s;
  logic [ASM_W-1:0]     asm_sof_s;
  logic [WIDTH-1:0]     load_word_s;

  function automatic logic [GRP_W-1:0] grp_next(input logic [GRP_W-1:0] g);
    logic [GRP_W-1:0] n;
    if (g == LAST_GRP) begin
      n = {GRP_W{1'b0}};
    end else begin
      n = g + GRP_W'(1);
    end
    return n;
  endfunction

  // Closing chunk may only enter when the holding register is free or being drained.
  assign in_ready  = rdy_en_r & ((chunk_cnt_r != LAST_CHUNK) | ~out_valid | out_ready);
  assign accept_s  = in_valid & in_ready;
  assign asm_sof_s = ASM_W'(in_data);

  if (CHUNKS == 1) begin : g_one_chunk
    assign load_word_s = in_data;
    assign asm_shift_s = asm_r;
  end else if (CHUNKS == 2) begin : g_two_chunk
    assign load_word_s = {asm_r, in_data};
    assign asm_shift_s = in_data;
  end else begin : g_multi_chunk
    assign load_word_s = {asm_r, in_data};
    assign asm_shift_s = {asm_r[ASM_W-IN_W-1:0], in_data};
  end

  // Next-state for chunk/group counters, assembly register and group load.
  always_comb begin
    chunk_nxt_s = chunk_cnt_r;
    grp_nxt_s   = grp_cnt_r;
    asm_nxt_s   = asm_r;
    load_s      = 1'b0;
    load_grp_s  = grp_cnt_r;
    err_nxt_s   = 1'b0;
    if (accept_s) begin
      if (in_sof) begin
        // A sof chunk restarts the frame; a pending partial group is discarded.
        err_nxt_s  = (chunk_cnt_r != {CNT_W{1'b0}});
        asm_nxt_s  = asm_sof_s;
        load_grp_s = {GRP_W{1'b0}};
        if (CHUNKS == 1) begin
          load_s      = 1'b1;
          chunk_nxt_s = {CNT_W{1'b0}};
          grp_nxt_s   = grp_next({GRP_W{1'b0}});
        end else begin
          chunk_nxt_s = CNT_W'(1);
          grp_nxt_s   = {GRP_W{1'b0}};
        end
      end else if (chunk_cnt_r == LAST_CHUNK) begin
        load_s      = 1'b1;
        chunk_nxt_s = {CNT_W{1'b0}};
        grp_nxt_s   = grp_next(grp_cnt_r);
      end else begin
        asm_nxt_s   = asm_shift_s;
        chunk_nxt_s = chunk_cnt_r + CNT_W'(1);
      end
    end else begin
      chunk_nxt_s = chunk_cnt_r;
      grp_nxt_s   = grp_cnt_r;
    end
  end

  // Assembly state and output holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_r    <= 1'b0;
      chunk_cnt_r <= {CNT_W{1'b0}};
      grp_cnt_r   <= {GRP_W{1'b0}};
      asm_r       <= {ASM_W{1'b0}};
      out_data    <= {WIDTH{1'b0}};
      out_grp     <= {GRP_W{1'b0}};
      out_last    <= 1'b0;
      out_valid   <= 1'b0;
      err_sync    <= 1'b0;
    end else begin
      rdy_en_r    <= 1'b1;
      chunk_cnt_r <= chunk_nxt_s;
      grp_cnt_r   <= grp_nxt_s;
      asm_r       <= asm_nxt_s;
      err_sync    <= err_nxt_s;
      if (load_s) begin
        out_data  <= load_word_s;
        out_grp   <= load_grp_s;
        out_last  <= (load_grp_s == LAST_GRP);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_info_packer.sv
// Directed plus random bench for ldpc_info_packer against a byte-queue reference model.
module tb_ldpc_info_packer;

  localparam int W  = 360;
  localparam int K  = 90;
  localparam int CH = 45;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [6:0]   out_grp;
  logic         out_last;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         err_sync;

  always #5 clk = ~clk;

  ldpc_info_packer #(.WIDTH(W), .IN_W(8), .K_GROUPS(K)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .out_data(out_data), .out_grp(out_grp), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .err_sync(err_sync)
  );

  int total = 0;
  int bad   = 0;

  // reference model: bytes of the group being built, next index, held group
  logic [7:0]   m_part[$];
  int           m_grp;
  bit           m_hv;
  logic [W-1:0] m_hd;
  int           m_hg;
  bit           m_err;
  bit           m_rdy_en;

  // values observed at the most recent sample point
  logic         s_rdy, s_valid, s_last, s_err;
  logic [W-1:0] s_data;
  logic [6:0]   s_grp;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_part.delete();
    m_grp = 0; m_hv = 0; m_hd = '0; m_hg = 0; m_err = 0; m_rdy_en = 0;
  endtask

  function automatic logic [W-1:0] pack_part();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) r[W-1-8*i -: 8] = m_part[i];
    return r;
  endfunction

  task automatic step(input bit v, input bit sof, input logic [7:0] d, input bit ordy, output bit acc);
    bit exp_rdy, take, load;
    @(negedge clk);
    in_valid = v; in_sof = sof; in_data = d; out_ready = ordy;
    #1;
    s_rdy = in_ready; s_valid = out_valid; s_data = out_data;
    s_grp = out_grp; s_last = out_last; s_err = err_sync;
    exp_rdy = !rst && m_rdy_en && !(m_part.size() == CH - 1 && m_hv && !ordy);
    chk("in_ready", W'(s_rdy), W'(exp_rdy));
    chk("out_valid", W'(s_valid), W'(m_hv));
    chk("out_data", s_data, m_hd);
    chk("out_grp", W'(s_grp), W'(m_hg));
    chk("out_last", W'(s_last), W'(m_hg == K - 1));
    chk("err_sync", W'(s_err), W'(m_err));
    acc  = v && exp_rdy;
    take = m_hv && ordy;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      load  = 0;
      m_err = 0;
      if (acc) begin
        if (sof) begin
          m_err = (m_part.size() != 0);
          m_part.delete();
          m_grp = 0;
        end
        m_part.push_back(d);
        if (m_part.size() == CH) begin
          m_hd = pack_part(); m_hg = m_grp; m_hv = 1; load = 1;
          m_part.delete();
          m_grp = (m_grp + 1) % K;
        end
      end
      if (!load && take) m_hv = 0;
      m_rdy_en = 1;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit sof, input bit ordy);
    bit a;
    int n;
    n = 0;
    do begin
      step(1'b1, sof, d, ordy, a);
      n++;
    end while (!a && n < 64);
    chk("send_bound", W'(a), W'(1'b1));
  endtask

  bit   a;
  int   nlast, lastgrp, firstgrp, nerr, taken, cyc;
  bit   rv, rsof, rordy, was_hv;

  initial begin
    model_reset();
    // reset state
    step(1'b0, 1'b0, 8'h00, 1'b0, a);
    chk("rst_valid", W'(s_valid), W'(1'b0));
    chk("rst_data", s_data, W'(0));
    chk("rst_rdy", W'(s_rdy), W'(1'b0));
    #3 rst = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b1, a);

    // 1: one group of bytes 0x00..0x2C
    for (int i = 0; i < CH; i++) send(8'(i), 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, a);
    chk("t1_valid", W'(s_valid), W'(1'b1));
    chk("t1_first", W'(s_data[359:352]), W'(8'h00));
    chk("t1_lastbyte", W'(s_data[7:0]), W'(8'h2C));
    chk("t1_grp", W'(s_grp), W'(0));

    // 2: consumer stalled across two groups, then drained back to back
    for (int i = 0; i < 89; i++) send(8'(i) ^ 8'h5A, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h03, 1'b0, a);
    chk("t2_stall", W'(s_rdy), W'(1'b0));
    step(1'b1, 1'b0, 8'h03, 1'b1, a);
    chk("t2_take_valid", W'(s_valid), W'(1'b1));
    chk("t2_take_grp", W'(s_grp), W'(1));
    step(1'b0, 1'b0, 8'h00, 1'b1, a);
    chk("t2_nobubble", W'(s_valid), W'(1'b1));
    chk("t2_grp2", W'(s_grp), W'(2));
    step(1'b0, 1'b0, 8'h00, 1'b1, a);
    chk("t2_drained", W'(s_valid), W'(1'b0));

    // 3: full frame plus the first group of the next one
    nlast = 0; lastgrp = -1; firstgrp = -1;
    for (int g = 0; g < K + 1; g++) begin
      for (int c = 0; c < CH; c++) begin
        send(8'($urandom), (g % K == 0) && (c == 0), 1'b1);
        if (s_valid && s_last) begin nlast++; lastgrp = int'(s_grp); end
        if (s_valid && g == 1 && c == 0) firstgrp = int'(s_grp);
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, a);
    chk("t3_nlast", W'(nlast), W'(1));
    chk("t3_lastgrp", W'(lastgrp), W'(89));
    chk("t3_firstgrp", W'(firstgrp), W'(0));
    chk("t3_nextframe_grp", W'(s_grp), W'(0));
    chk("t3_nextframe_valid", W'(s_valid), W'(1'b1));

    // 4: sof arriving with a partial group pending
    for (int i = 0; i < 10; i++) send(8'(i + 100), 1'b0, 1'b1);
    send(8'hA5, 1'b1, 1'b1);
    nerr = 0;
    for (int i = 0; i < CH - 1; i++) begin
      send(8'(i), 1'b0, 1'b1);
      if (s_err) nerr++;
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, a);
    if (s_err) nerr++;
    chk("t4_err_once", W'(nerr), W'(1));
    chk("t4_first", W'(s_data[359:352]), W'(8'hA5));
    chk("t4_grp", W'(s_grp), W'(0));
    step(1'b0, 1'b0, 8'h00, 1'b1, a);

    // 5: asynchronous reset while a group is held and another is half built
    for (int i = 0; i < CH + 20; i++) send(8'(i * 3), 1'b0, 1'b0);
    chk("t5_held", W'(s_valid), W'(1'b1));
    #3 rst = 1'b1;
    #1;
    chk("t5_async_valid", W'(out_valid), W'(1'b0));
    chk("t5_async_rdy", W'(in_ready), W'(1'b0));
    model_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0, a);
    #3 rst = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b1, a);
    for (int i = 0; i < CH; i++) send(8'(i + 7), 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, a);
    chk("t5_valid", W'(s_valid), W'(1'b1));
    chk("t5_grp", W'(s_grp), W'(0));

    // 6: random valid/ready traffic, occasional sof
    taken = 0; cyc = 0;
    while (taken < 1000 && cyc < 70000) begin
      rv     = ($urandom_range(0, 15) != 0);
      rordy  = ($urandom_range(0, 4) != 0);
      rsof   = rv && ($urandom_range(0, 599) == 0);
      was_hv = m_hv;
      step(rv, rsof, 8'($urandom), rordy, a);
      if (was_hv && rordy) taken++;
      cyc++;
    end
    chk("t6_groups", W'(taken >= 1000), W'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
